// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU instruction sequencer.
// Opcodes, instruction field positions, FSM states and the quiet-NaN result.
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_t;

    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 3;
    localparam int RSVD_BIT = 2;
    localparam int OP_MSB   = 1;
    localparam int OP_LSB   = 0;

    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_HALT
    } state_t;

endpackage

// File: rtl/fpu_instr_sequencer.sv
// Sequential FPU program runner: fetch, read operands, issue, wait, write.
// Define FPU_SEQ_WATCHDOG_EN to bound WAIT and report timeouts.
module fpu_instr_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int PROG_LEN       = 44,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [7:0]    pc_addr,
    input  logic [15:0]   instr,
    output logic [12:0]   dmem_addr,
    output logic          dmem_rd_en,
    input  logic [127:0]  dmem_rdata,
    output logic [1:0]    fpu_op,
    output logic [63:0]   fpu_a,
    output logic [63:0]   fpu_b,
    output logic          fpu_start,
    input  logic          fpu_done,
    input  logic [63:0]   fpu_result,
    output logic          res_valid,
    output logic [63:0]   res_data,
    output logic [7:0]    res_pc,
    output logic          busy,
    output logic          halted,
    output logic          illegal_err,
    output logic          timeout_err
);

    localparam logic [7:0] LAST_PC = 8'(PROG_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  pc;
    logic [1:0]  ir_op;
    logic        last;
    logic        rsvd;
    logic        wd_expired;

    assign last      = (pc == LAST_PC);
    assign rsvd      = instr[RSVD_BIT];
    assign pc_addr   = pc;
    assign res_pc    = pc;
    assign fpu_op    = ir_op;
    assign dmem_addr = instr[ADDR_MSB:ADDR_LSB];

`ifdef FPU_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expired = (state == S_WAIT) && !fpu_done && (wd_cnt == WD_LAST);

    // WAIT-cycle counter, cleared whenever the FSM is outside WAIT
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) wd_cnt <= '0;
        else                        wd_cnt <= wd_cnt + 1'b1;
    end

    // sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst)             timeout_err <= 1'b0;
        else if (wd_expired) timeout_err <= 1'b1;
    end
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state and strobe decode
    always_comb begin
        state_nxt  = state;
        dmem_rd_en = 1'b0;
        fpu_start  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (!rsvd) begin
                    dmem_rd_en = 1'b1;
                    state_nxt  = S_READ;
                end else begin
                    state_nxt  = last ? S_HALT : S_FETCH;
                end
            end
            S_READ:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                fpu_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_done || wd_expired) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                res_valid = 1'b1;
                state_nxt = last ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (!run) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // PC, instruction register, operands, result and illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            ir_op       <= '0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            res_data    <= '0;
            illegal_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: pc <= '0;
                S_FETCH: begin
                    ir_op <= instr[OP_MSB:OP_LSB];
                    if (rsvd) begin
                        illegal_err <= 1'b1;
                        if (!last) pc <= pc + 8'd1;
                    end
                end
                S_READ: begin
                    fpu_a <= dmem_rdata[127:64];
                    fpu_b <= dmem_rdata[63:0];
                end
                S_WAIT: begin
                    if (fpu_done)        res_data <= fpu_result;
                    else if (wd_expired) res_data <= QNAN;
                end
                S_WRITE: if (!last) pc <= pc + 8'd1;
                S_HALT:  if (!run) pc <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fpu_instr_sequencer.md
FPU_INSTR_SEQUENCER -- requirements
Module: fpu_instr_sequencer

Interface
REQ-001 SHALL have parameter PROG_LEN, default 44, number of instruction slots executed (PC 0..PROG_LEN-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles when the watchdog is compiled in.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level; starts execution from PC 0 when sampled high in IDLE.
REQ-006 pc_addr  out  8  instruction-memory address.
REQ-007 instr  in  16  instruction {addr[15:3], reserved[2], opcode[1:0]}, combinational from pc_addr.
REQ-008 dmem_addr  out  13  data-memory operand address; dmem_rd_en  out  1  read strobe.
REQ-009 dmem_rdata  in  128  {opA[127:64], opB[63:0]}, valid the cycle after dmem_rd_en.
REQ-010 fpu_op  out  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; fpu_a, fpu_b  out  64  operands.
REQ-011 fpu_start  out  1  one-cycle issue pulse; fpu_done  in  1  result valid; fpu_result  in  64.
REQ-012 res_valid  out  1  one-cycle result strobe; res_data  out  64; res_pc  out  8  PC of the result.
REQ-013 busy, halted, illegal_err, timeout_err  out  1 each  status.

Function
REQ-014 States SHALL be IDLE, FETCH, READ, ISSUE, WAIT, WRITE, HALT.
REQ-015 IDLE: pc=0; run=1 -> FETCH.
REQ-016 FETCH: latch instr into IR; if reserved=0, assert dmem_rd_en with dmem_addr=instr[15:3] in this cycle -> READ.
REQ-017 FETCH with reserved=1: set illegal_err (sticky), no dmem read, no res_valid, pc+1 -> FETCH, or HALT if pc==PROG_LEN-1.
REQ-018 READ: latch opA/opB from dmem_rdata -> ISSUE.
REQ-019 ISSUE: fpu_start=1 for exactly one cycle; fpu_op/fpu_a/fpu_b held stable from ISSUE until WAIT exits -> WAIT.
REQ-020 WAIT: fpu_done=1 -> latch fpu_result -> WRITE; fpu_done during ISSUE is ignored.
REQ-021 WRITE: res_valid=1 for one cycle with res_data and res_pc=pc; then pc==PROG_LEN-1 -> HALT, else pc+1 -> FETCH.
REQ-022 Instruction latency SHALL be 4+N cycles, N = WAIT cycles (N>=1); no pipelining, one instruction in flight.
REQ-023 HALT: halted=1; run=0 -> IDLE; run=1 holds HALT.
REQ-024 busy=1 in every state except IDLE and HALT; run deassertion mid-program is ignored.
REQ-025 pc SHALL never exceed PROG_LEN-1 and never wrap.

Reset
REQ-026 rst SHALL force IDLE, pc=0, all strobes 0, fpu_a/fpu_b/res_data/res_pc=0, all status flags 0, from any state including WAIT.
REQ-027 A fpu_done arriving after a reset during WAIT SHALL be ignored.

Configuration
REQ-028 Macro FPU_SEQ_WATCHDOG_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without fpu_done set timeout_err (sticky), res_data=64'h7FF8000000000000 -> WRITE.
REQ-029 Without FPU_SEQ_WATCHDOG_EN: WAIT is unbounded, timeout_err tied 0, no counter.

Structure
REQ-030 Shared package fpu_seq_pkg SHALL hold the opcode encodings, instruction field positions, state encoding and the QNAN constant.
REQ-031 Single FSM module; no sub-module.

Verification
REQ-032 Run PROG_LEN=44, FPU done 3 cycles after start -> 44 res_valid pulses, res_pc 0..43 in order, 7 cycles apart, then halted=1.
REQ-033 instr=16'h0012 -> dmem_addr=2, fpu_op=10; opA=3.0, opB=2.0 -> res_data=64'h4018000000000000 (6.0).
REQ-034 Reserved bit set at PC 5 -> illegal_err=1, no res_pc=5 pulse, PC 6 executes next.
REQ-035 rst asserted during WAIT at PC 10 -> next cycle IDLE, pc_addr=0; late fpu_done gives no res_valid.
REQ-036 With FPU_SEQ_WATCHDOG_EN, fpu_done never asserted -> after 255 WAIT cycles timeout_err=1, res_data=64'h7FF8000000000000, next PC fetched.
